// File: rtl/arb_pkg.sv
// Shared definitions for the arbitrated multiplexer: policy codes and the
// channel-index width helper.
package arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Width needed to encode a channel index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational masked priority picker. Scans req starting at index 0
// (fixed priority) or at start (round-robin), wrapping N-1 -> 0, and returns
// the first requester as both a one-hot grant and a binary index.
module arb_pick
  import arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int CW   = 2,
  parameter int MODE = ARB_FIXED
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [CW-1:0] idx
);

  logic [CW-1:0] pos;
  logic          found;

  // First set request in search order wins; at most one grant bit is set.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      if (MODE == ARB_RR) pos = CW'((int'(start) + k) % N);
      else                pos = CW'(k);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// N-input arbitrated multiplexer with valid/ready handshakes. Requesting
// channels are arbitrated by fixed priority or round-robin, optionally locked
// to the last winner, and the winning word is captured in a single output
// register so there is no combinational path from in_data to out_data.
module arb_mux_n
  import arb_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  parameter  int MODE  = ARB_FIXED,
  localparam int CW    = idx_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic             lock,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_chan,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [CW-1:0]    ptr;
  logic [CW-1:0]    last_chan;
  logic             has_grant;
  logic             load;
  logic [N-1:0]     lock_mask;
  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic [CW-1:0]    pick_idx;
  logic [WIDTH-1:0] sel_data;

  // The output register can take a new word when empty or being drained.
  assign load = ~out_valid | out_ready;

  // Locking narrows eligibility to the last winner, but only once one exists.
  always_comb begin
    lock_mask = '1;
    if (lock && has_grant) lock_mask = N'(1) << last_chan;
  end

  // No requests reach the picker while stalled, so grant (and in_ready) is 0.
  assign req = load ? (in_valid & lock_mask) : '0;

  arb_pick #(
    .N    (N),
    .CW   (CW),
    .MODE (MODE)
  ) u_pick (
    .req   (req),
    .start (ptr),
    .grant (grant),
    .idx   (pick_idx)
  );

  // A granted channel's word is taken in the same cycle; nothing is taken in reset.
  assign in_ready = rst ? '0 : grant;

  // One-hot select of the winning channel's word into the output register.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output register and arbitration state; everything holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
      last_chan <= '0;
      has_grant <= 1'b0;
    end else if (load) begin
      if (|grant) begin
        out_data  <= sel_data;
        out_chan  <= pick_idx;
        out_valid <= 1'b1;
        last_chan <= pick_idx;
        has_grant <= 1'b1;
        if (MODE == ARB_RR) begin
          if (pick_idx == CW'(N - 1)) ptr <= '0;
          else                        ptr <= pick_idx + CW'(1);
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: three instances cover fixed priority (N=4),
// round-robin (N=4) and the single-channel case (N=1, WIDTH=8). Expected
// words are queued when a grant is expected and popped when the output loads.
module tb_arb_mux_n;
  import arb_pkg::*;

  typedef struct {
    int          chan;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Fixed-priority instance
  logic [127:0] d0;
  logic [3:0]   v0, r0;
  logic         l0, ov0, or0;
  logic [31:0]  od0;
  logic [1:0]   oc0;

  // Round-robin instance
  logic [127:0] d1;
  logic [3:0]   v1, r1;
  logic         l1, ov1, or1;
  logic [31:0]  od1;
  logic [1:0]   oc1;

  // Single-channel instance
  logic [7:0]   d2;
  logic [0:0]   v2, r2;
  logic         l2, ov2, or2;
  logic [7:0]   od2;
  logic [0:0]   oc2;

  arb_mux_n #(.WIDTH(32), .N(4), .MODE(ARB_FIXED)) u0 (
    .clk(clk), .rst(rst), .in_data(d0), .in_valid(v0), .in_ready(r0), .lock(l0),
    .out_data(od0), .out_chan(oc0), .out_valid(ov0), .out_ready(or0));

  arb_mux_n #(.WIDTH(32), .N(4), .MODE(ARB_RR)) u1 (
    .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1), .in_ready(r1), .lock(l1),
    .out_data(od1), .out_chan(oc1), .out_valid(ov1), .out_ready(or1));

  arb_mux_n #(.WIDTH(8), .N(1), .MODE(ARB_FIXED)) u2 (
    .clk(clk), .rst(rst), .in_data(d2), .in_valid(v2), .in_ready(r2), .lock(l2),
    .out_data(od2), .out_chan(oc2), .out_valid(ov2), .out_ready(or2));

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 + 32'(i * 32'h0101);
  endfunction

  function automatic logic [127:0] pats4();
    return {pat(3), pat(2), pat(1), pat(0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    d0 = '0; v0 = 4'b1111; l0 = 1'b0; or0 = 1'b1;
    d1 = '0; v1 = 4'b1111; l1 = 1'b0; or1 = 1'b1;
    d2 = '0; v2 = 1'b1;    l2 = 1'b0; or2 = 1'b1;
    step();
    step();
    vectors++; if (ov0 !== 1'b0) begin miscompares++; $display("FAIL reset_ov0 got %b want 0", ov0); end
    vectors++; if (od0 !== 32'h0) begin miscompares++; $display("FAIL reset_od0 got %h want 0", od0); end
    vectors++; if (oc0 !== 2'd0) begin miscompares++; $display("FAIL reset_oc0 got %0d want 0", oc0); end
    vectors++; if (r0 !== 4'b0000) begin miscompares++; $display("FAIL reset_rdy0 got %b want 0000", r0); end
    vectors++; if (ov1 !== 1'b0) begin miscompares++; $display("FAIL reset_ov1 got %b want 0", ov1); end
    vectors++; if (r1 !== 4'b0000) begin miscompares++; $display("FAIL reset_rdy1 got %b want 0000", r1); end
    vectors++; if (ov2 !== 1'b0 || od2 !== 8'h00) begin miscompares++; $display("FAIL reset_u2 got ov=%b od=%h want 0/00", ov2, od2); end
    v0 = '0; v1 = '0; v2 = '0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_fixed();
    exp_t e;
    d0 = pats4(); or0 = 1'b1; v0 = 4'b1010;
    #1;
    vectors++; if (r0 !== 4'b0010) begin miscompares++; $display("FAIL fixed_rdy_a got %b want 0010", r0); end
    sb.push_back('{1, pat(1)});
    step();
    e = sb.pop_front();
    vectors++; if (ov0 !== 1'b1 || oc0 !== 2'(e.chan) || od0 !== e.data) begin
      miscompares++; $display("FAIL fixed_out_a got v=%b ch=%0d d=%h want 1/%0d/%h", ov0, oc0, od0, e.chan, e.data); end
    v0 = 4'b1000;
    #1;
    vectors++; if (r0 !== 4'b1000) begin miscompares++; $display("FAIL fixed_rdy_b got %b want 1000", r0); end
    sb.push_back('{3, pat(3)});
    step();
    e = sb.pop_front();
    vectors++; if (ov0 !== 1'b1 || oc0 !== 2'(e.chan) || od0 !== e.data) begin
      miscompares++; $display("FAIL fixed_out_b got v=%b ch=%0d d=%h want 1/%0d/%h", ov0, oc0, od0, e.chan, e.data); end
    v0 = 4'b0000;
    step();
    vectors++; if (ov0 !== 1'b0) begin miscompares++; $display("FAIL fixed_drain got %b want 0", ov0); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    d0 = pats4(); or0 = 1'b1; v0 = 4'b1111;
    #1;
    sb.push_back('{0, pat(0)});
    step();
    e = sb.pop_front();
    vectors++; if (ov0 !== 1'b1 || oc0 !== 2'(e.chan) || od0 !== e.data) begin
      miscompares++; $display("FAIL bp_first got v=%b ch=%0d d=%h want 1/%0d/%h", ov0, oc0, od0, e.chan, e.data); end
    or0 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      d0 = {$urandom, $urandom, $urandom, $urandom};
      #1;
      vectors++; if (r0 !== 4'b0000) begin miscompares++; $display("FAIL bp_rdy%0d got %b want 0000", c, r0); end
      step();
      vectors++; if (ov0 !== 1'b1 || od0 !== pat(0)) begin
        miscompares++; $display("FAIL bp_hold%0d got v=%b d=%h want 1/%h", c, ov0, od0, pat(0)); end
    end
    or0 = 1'b1;
    #1;
    vectors++; if (r0 !== 4'b0001) begin miscompares++; $display("FAIL bp_release_rdy got %b want 0001", r0); end
    sb.push_back('{0, d0[31:0]});
    step();
    e = sb.pop_front();
    vectors++; if (ov0 !== 1'b1 || oc0 !== 2'(e.chan) || od0 !== e.data) begin
      miscompares++; $display("FAIL bp_release_out got v=%b ch=%0d d=%h want 1/%0d/%h", ov0, oc0, od0, e.chan, e.data); end
    v0 = 4'b0000;
    step();
  endtask

  task automatic test_lock();
    exp_t e;
    d0 = pats4(); or0 = 1'b1; l0 = 1'b0; v0 = 4'b0100;
    #1;
    sb.push_back('{2, pat(2)});
    step();
    e = sb.pop_front();
    vectors++; if (ov0 !== 1'b1 || oc0 !== 2'(e.chan) || od0 !== e.data) begin
      miscompares++; $display("FAIL lock_grant got v=%b ch=%0d d=%h want 1/%0d/%h", ov0, oc0, od0, e.chan, e.data); end
    l0 = 1'b1; v0 = 4'b0011;
    #1;
    vectors++; if (r0 !== 4'b0000) begin miscompares++; $display("FAIL lock_block_rdy got %b want 0000", r0); end
    step();
    vectors++; if (ov0 !== 1'b0) begin miscompares++; $display("FAIL lock_drain got %b want 0", ov0); end
    v0 = 4'b0111;
    #1;
    vectors++; if (r0 !== 4'b0100) begin miscompares++; $display("FAIL lock_regrant_rdy got %b want 0100", r0); end
    sb.push_back('{2, pat(2)});
    step();
    e = sb.pop_front();
    vectors++; if (ov0 !== 1'b1 || oc0 !== 2'(e.chan) || od0 !== e.data) begin
      miscompares++; $display("FAIL lock_regrant got v=%b ch=%0d d=%h want 1/%0d/%h", ov0, oc0, od0, e.chan, e.data); end
    l0 = 1'b0; v0 = 4'b0000;
    step();
  endtask

  task automatic test_rr();
    exp_t e;
    d1 = pats4(); or1 = 1'b1; v1 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++; if (r1 !== (4'b0001 << (k % 4))) begin
        miscompares++; $display("FAIL rr_rdy%0d got %b want %b", k, r1, 4'b0001 << (k % 4)); end
      sb.push_back('{k % 4, pat(k % 4)});
      step();
      e = sb.pop_front();
      vectors++; if (ov1 !== 1'b1 || oc1 !== 2'(e.chan) || od1 !== e.data) begin
        miscompares++; $display("FAIL rr_out%0d got v=%b ch=%0d d=%h want 1/%0d/%h", k, ov1, oc1, od1, e.chan, e.data); end
    end
    v1 = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    d1 = pats4();
    d1[63:32] = 32'hDEADBEEF;
    v1 = 4'b0010; or1 = 1'b0;
    #1;
    vectors++; if (r1 !== 4'b0010) begin miscompares++; $display("FAIL rmid_rdy got %b want 0010", r1); end
    step();
    vectors++; if (ov1 !== 1'b1 || od1 !== 32'hDEADBEEF || oc1 !== 2'd1) begin
      miscompares++; $display("FAIL rmid_load got v=%b ch=%0d d=%h want 1/1/deadbeef", ov1, oc1, od1); end
    v1 = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (ov1 !== 1'b0 || od1 !== 32'h0 || oc1 !== 2'd0) begin
      miscompares++; $display("FAIL rmid_async got v=%b ch=%0d d=%h want 0/0/0", ov1, oc1, od1); end
    vectors++; if (r1 !== 4'b0000) begin miscompares++; $display("FAIL rmid_rdy_in_reset got %b want 0000", r1); end
    step();
    rst = 1'b0;
    or1 = 1'b1;
    #1;
    vectors++; if (r1 !== 4'b0001) begin miscompares++; $display("FAIL rmid_first_rdy got %b want 0001", r1); end
    sb.push_back('{0, d1[31:0]});
    step();
    e = sb.pop_front();
    vectors++; if (ov1 !== 1'b1 || oc1 !== 2'(e.chan) || od1 !== e.data) begin
      miscompares++; $display("FAIL rmid_first_out got v=%b ch=%0d d=%h want 1/%0d/%h", ov1, oc1, od1, e.chan, e.data); end
    v1 = 4'b0000;
    step();
  endtask

  task automatic test_single();
    exp_t e;
    d2 = 8'hA5; v2 = 1'b1; or2 = 1'b1;
    #1;
    vectors++; if (r2 !== 1'b1) begin miscompares++; $display("FAIL n1_rdy got %b want 1", r2); end
    sb.push_back('{0, 32'h0000_00A5});
    step();
    e = sb.pop_front();
    vectors++; if (ov2 !== 1'b1 || oc2 !== 1'(e.chan) || od2 !== e.data[7:0]) begin
      miscompares++; $display("FAIL n1_out got v=%b ch=%0d d=%h want 1/%0d/%h", ov2, oc2, od2, e.chan, e.data[7:0]); end
    v2 = 1'b0; d2 = 8'h3C;
    step();
    vectors++; if (ov2 !== 1'b0 || od2 !== 8'hA5) begin
      miscompares++; $display("FAIL n1_idle got v=%b d=%h want 0/a5", ov2, od2); end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_backpressure();
    test_lock();
    test_rr();
    test_reset_mid();
    test_single();
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arb_mux_n.md
# arb_mux_n

Parametrised N-input, WIDTH-bit arbitrated multiplexer with valid/ready handshakes and a registered output stage. It is the sequential successor to the pipeline's fixed 4:1 32-bit select mux. Instead of a caller-driven select, it picks among requesting channels by fixed priority or round-robin, optionally locks onto one channel, and registers the winner. It sits wherever several producers share one consumer, e.g. instruction-fetch vs. data-memory requests onto the single memory port.

## Interface
- WIDTH, 32, data width per channel (≥1)
- N, 4, number of input channels (≥1)
- MODE, 0, arbitration policy: 0 = fixed priority (lowest index wins), 1 = round-robin
- CW, derived = max(1, $clog2(N)), channel-index width; not overridable
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N  channel i offers a word
- in_ready  out  N  channel i's word is taken this cycle
- lock  in  1  restrict arbitration to the last granted channel
- out_data  out  WIDTH  registered selected word
- out_chan  out  CW  index of the channel that supplied out_data
- out_valid  out  1  out_data/out_chan hold an untaken word
- out_ready  in  1  consumer accepts the word this cycle

## Operation
- Output register load enable: load = ~out_valid | out_ready.
- Eligible set: E = in_valid, or, if lock=1 and a prior grant exists, E = in_valid & onehot(last_chan).
- Grant: when load=1 and E≠0, exactly one grant bit is set. Otherwise grant=0.
  - MODE 0: lowest set index of E.
  - MODE 1: first set index of E searching upward from ptr, wrapping N−1→0.
- in_ready = grant. This is combinational from in_valid, lock, out_valid, out_ready and state. A channel transfers when in_valid[i] & in_ready[i].
- On grant to channel g:
  - out_data ← in_data[g]
  - out_chan ← g
  - out_valid ← 1
  - last_chan ← g
  - has_grant ← 1
  - MODE 1 only: ptr ← (g+1) mod N, wrapping at N−1 to 0
- On load with no grant: out_valid ← 0. out_data and out_chan hold their values.
- When load=0, the output is stalled and all state holds.
- A stalled word stays on out_data unchanged, regardless of input activity.
- lock=1 with last channel not valid: no grant. Other channels wait, and the output drains to out_valid=0.
- lock=1 before any grant since reset (has_grant=0): behaves as lock=0.
- N=1: always grants channel 0 when valid. ptr stays 0. out_chan width is 1, value 0.
- Reset mid-transfer: the pending word is discarded and the producer must re-offer it. Outputs go to reset values immediately, asynchronously.

## Timing
- Reset values: out_valid=0, out_data=0, out_chan=0, ptr=0, last_chan=0, has_grant=0. in_ready=0 while rst=1.
- Latency: 1 cycle from an accepted in_valid/in_ready beat to out_valid.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Full-rate pass-through: out_ready=1 and out_valid=1 in the same cycle as a new grant. The old word leaves and the new word loads on the same edge.
- Back-pressure: out_valid=1 with out_ready=0 forces in_ready=0 on all channels in that cycle.
- No combinational path from in_data to out_data.

## Structure
- Shared package arb_pkg holds:
  - localparams ARB_FIXED=0 and ARB_RR=1
  - a clog2-based width helper function used for CW
- One sub-module, arb_pick: combinational masked priority picker. Inputs: req[N], start index, MODE. Outputs: one-hot grant and binary index.
- arb_mux_n instantiates arb_pick once and contains the output register, ptr, last_chan and has_grant.

## Test plan
- Fixed priority, MODE=0, N=4: in_valid=4'b1010 with out_ready=1 → channel 1 granted. out_chan=1 and out_data=in_data[1] on the next cycle. With in_valid=4'b1000 on the following cycle → channel 3.
- Round-robin wrap, MODE=1: all four valid for 5 cycles with out_ready=1 → out_chan sequence 0,1,2,3,0. ptr wraps 3→0.
- Back-pressure: out_valid=1, out_ready=0 for 3 cycles with in_valid=4'b1111 → in_ready=0 all cycles and out_data held constant. Release → next grant on the release cycle, data visible 1 cycle later.
- Lock: grant channel 2, then lock=1 with in_valid=4'b0011 → no grant and out_valid drops to 0. Raise in_valid[2] → channel 2 granted.
- Reset mid-operation: assert rst asynchronously while out_valid=1, out_data=32'hDEADBEEF → out_valid=0 and out_data=0 immediately. After release with MODE=1, the first grant goes to channel 0 (ptr=0).
- Degenerate case, N=1, WIDTH=8: in_valid pulsed with data 8'hA5 → out_data=8'hA5 and out_chan=0 one cycle later.
